ram_pair_reader: RTL
====================

Name: ram_pair_reader

Overview:
- Read-side initiator for the dual-read-port register RAM.
- Takes a start/base/count command, then drives both RAM read addresses to fetch consecutive word pairs: port0 reads the even-offset word, port1 reads the odd-offset word.
- Absorbs the RAM's 1-cycle registered read latency and presents each pair on a valid/ready output stream with backpressure.
- Sits between the RAM read ports and consumers such as the ALU operand path, dump logic or a display streamer.

Parameters:
DATA_WIDTH  16  width of each RAM word and each output data word
ADDR_WIDTH  8  RAM address width
MEM_SIZE  16  highest valid RAM address; the RAM holds MEM_SIZE+1 words
FIFO_DEPTH  4  output buffer entries; fixed at 4 for the credit rule below

Ports:
Clock  in  1  single clock, rising edge
Reset  in  1  synchronous, active-high
iStart  in  1  command strobe; sampled only in IDLE
iBaseAddr  in  ADDR_WIDTH  first port0 address; must be <= MEM_SIZE
iPairCount  in  ADDR_WIDTH  number of pairs to read; 0 is legal
oReadAddress0  out  ADDR_WIDTH  to RAM iReadAddress0
oReadAddress1  out  ADDR_WIDTH  to RAM iReadAddress1
iRamData0  in  DATA_WIDTH  from RAM oDataOut0
iRamData1  in  DATA_WIDTH  from RAM oDataOut1
oPairValid  out  1  output pair available
iPairReady  in  1  consumer accepts the pair
oData0  out  DATA_WIDTH  word read at the even offset
oData1  out  DATA_WIDTH  word read at the odd offset
oBusy  out  1  high outside IDLE
oDone  out  1  one-cycle pulse when the command completes

Behaviour:
- Reset (synchronous, takes priority over all other inputs):
  - state goes to IDLE; FIFO is emptied; pending flag is cleared.
  - address registers are set to 0.
  - outputs: oPairValid=0, oData0=0, oData1=0, oBusy=0, oDone=0.
  - Reset during RUN or DRAIN aborts the command. No pair is emitted afterwards and oDone is not pulsed.
- States:
  - IDLE: if iStart=1, latch iBaseAddr and iPairCount and go to RUN. If the latched count is 0, go to DRAIN instead.
  - RUN: issue reads. After the last issue, go to DRAIN.
  - DRAIN: when pending=0, FIFO is empty and no pop occurs this cycle, pulse oDone and return to IDLE.
- iStart in RUN or DRAIN is ignored. It is not queued.
- Address generation:
  - oReadAddress0 = current pointer a.
  - oReadAddress1 = a+1, wrapped to 0 when a = MEM_SIZE.
  - After each issue, a advances by 2 modulo (MEM_SIZE+1). Example with MEM_SIZE=16: a=15 reads 15 and 16, then a becomes 0; a=16 reads 16 and 0, then a becomes 1.
  - Addresses are registered outputs and are held stable while stalled.
- Issue rule (in RUN):
  - Issue when remaining>0 and (fifo_count + pending) <= 2.
  - An issue in cycle c sets pending=1 for cycle c+1.
  - In cycle c+1, iRamData0/1 hold the data for that issue and are pushed into the FIFO at the end of c+1.
  - This rule never overflows the 4-entry FIFO.
  - iPairReady is not used in the issue decision, so there is no combinational path from ready to address.
- Latency and throughput:
  - iStart is sampled at the end of cycle T.
  - The first address is driven in T+1.
  - Data is captured at the end of T+2.
  - oPairValid is first high in T+3.
  - With iPairReady held at 1, the block sustains 1 pair per cycle.
- Output handshake:
  - A pair transfers when oPairValid && iPairReady.
  - oData0/1 hold stable while valid and not ready.
  - oData0/1 are taken from the FIFO head and are don't-care when oPairValid=0.
- Simultaneous push and pop in one cycle leave fifo_count unchanged.
- Completion: oDone is high for exactly one cycle, in the cycle after the final handshake. For count=0, oDone is high in T+2.
- RAM writes during a read: the block captures whatever the RAM returns (read-before-write on same-address collisions). It does not detect or order writes.
- Width rule: remaining is a down-counter of ADDR_WIDTH bits with no wrap. Counts greater than the number of pairs in memory simply re-read wrapped addresses.

Decomposition:
- Shared package: the state encoding (IDLE, RUN, DRAIN), FIFO_DEPTH, and the issue-threshold constant (2).
- One sub-module: pair_fifo, a synchronous 4-entry FIFO of width 2*DATA_WIDTH with push, pop, count, empty and full. It is reusable by a later stream writer.

Test Plan:
- RAM preloaded with word[i]=16'h1000+i, base=0, count=4, ready=1 -> pairs (1000,1001), (1002,1003), (1004,1005), (1006,1007); first valid at T+3; consecutive cycles; oDone exactly once in the cycle after the 4th handshake.
- base=15, count=2, MEM_SIZE=16 -> addresses (15,16) then (0,1); outputs (100F,1010), (1000,1001).
- count=3, ready held 0 for 10 cycles then 1 -> at most 3 pairs issued while stalled; no FIFO overflow; oData stable while stalled; the 3 pairs delivered in order.
- count=0 -> oBusy high for 2 cycles, no oPairValid, oDone pulses in T+2.
- Reset asserted 2 cycles after the first valid during count=8 -> next cycle oPairValid=0, oBusy=0; no oDone; a new start with base=4, count=1 returns (1004,1005).
- iStart re-pulsed during RUN with base=8 -> ignored; the original sequence completes unchanged.

Source files
------------

// File: rtl/ram_pair_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_pair_reader_pkg                                                  |
// | Shared state encoding, buffer sizing and address helper for the      |
// | dual-port RAM pair reader.                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ram_pair_reader_pkg;

  // Controller states: waiting for a command, issuing reads, draining output
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Output buffer depth; the issue threshold below is sized against it
  localparam int PAIR_FIFO_DEPTH = 4;

  // A new read is issued only while buffered plus in-flight pairs are at or
  // below this value, so an in-flight pair always has a free slot
  localparam int ISSUE_THRESHOLD = 2;

  // Circular address step over a memory holding top+1 words
  function automatic logic [31:0] wrap_addr(input logic [31:0] a,
                                            input logic [31:0] inc,
                                            input logic [31:0] top);
    return (a + inc) % (top + 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pair_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pair_fifo                                                            |
// | Small synchronous FIFO with push, pop, occupancy count, empty and    |
// | full flags. DEPTH must be a power of two (pointers wrap naturally).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pair_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  // A push into a full buffer is accepted only when a pop frees a slot
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage, pointers and occupancy; storage is cleared so the head reads 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_pair_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_pair_reader                                                      |
// | Read-side initiator for the dual-read-port RAM: walks consecutive    |
// | word pairs (even offset on port0, odd on port1), absorbs the 1-cycle |
// | read latency and streams pairs out on a valid/ready interface.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ram_pair_reader
  import ram_pair_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 16,
  parameter int FIFO_DEPTH = PAIR_FIFO_DEPTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [ADDR_WIDTH-1:0] iBaseAddr,
  input  logic [ADDR_WIDTH-1:0] iPairCount,
  output logic [ADDR_WIDTH-1:0] oReadAddress0,
  output logic [ADDR_WIDTH-1:0] oReadAddress1,
  input  logic [DATA_WIDTH-1:0] iRamData0,
  input  logic [DATA_WIDTH-1:0] iRamData1,
  output logic                  oPairValid,
  input  logic                  iPairReady,
  output logic [DATA_WIDTH-1:0] oData0,
  output logic [DATA_WIDTH-1:0] oData1,
  output logic                  oBusy,
  output logic                  oDone
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_addr0;
  logic [ADDR_WIDTH-1:0]   r_addr1;
  logic [ADDR_WIDTH-1:0]   r_remaining;
  logic                    r_pending;
  logic                    r_drain_seen;
  logic                    w_latch;
  logic                    w_issue;
  logic                    w_done;
  logic                    w_push;
  logic                    w_pop;
  logic [2*DATA_WIDTH-1:0] w_head;
  logic [CW-1:0]           w_fifo_count;
  logic                    w_fifo_empty;
  logic                    w_fifo_full;
  logic [CW:0]             w_occupancy;

  // Pairs already buffered plus the one whose data arrives this cycle
  assign w_occupancy = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_pending};
  assign w_pop       = !w_fifo_empty && iPairReady;
  assign w_push      = r_pending;

  assign oReadAddress0 = r_addr0;
  assign oReadAddress1 = r_addr1;
  assign oPairValid    = !w_fifo_empty;
  assign oData0        = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign oData1        = w_head[DATA_WIDTH-1:0];
  assign oBusy         = (r_state != ST_IDLE);
  assign oDone         = w_done;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, command latch, read issue and completion decisions.
  // Issue ignores iPairReady, keeping ready off the address path; the
  // occupancy bound alone guarantees every in-flight pair has room.
  // The DRAIN entry cycle never completes, so even a zero-count command
  // stays busy for two cycles and pulses done in its second cycle.
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          w_latch      = 1'b1;
          w_next_state = (iPairCount == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if ((r_remaining != '0) &&
            (w_occupancy <= (CW+1)'(ISSUE_THRESHOLD))) begin
          w_issue = 1'b1;
        end
        if (w_issue && (r_remaining == ADDR_WIDTH'(1))) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_drain_seen && !r_pending && w_fifo_empty && !w_pop) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Address pointers, pair counter and the read-in-flight flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_addr0      <= '0;
      r_addr1      <= '0;
      r_remaining  <= '0;
      r_pending    <= 1'b0;
      r_drain_seen <= 1'b0;
    end else begin
      r_pending    <= w_issue;
      r_drain_seen <= (r_state == ST_DRAIN);
      if (w_latch) begin
        r_addr0     <= iBaseAddr;
        r_addr1     <= ADDR_WIDTH'(wrap_addr(32'(iBaseAddr), 32'd1, 32'(MEM_SIZE)));
        r_remaining <= iPairCount;
      end else if (w_issue) begin
        r_addr0     <= ADDR_WIDTH'(wrap_addr(32'(r_addr0), 32'd2, 32'(MEM_SIZE)));
        r_addr1     <= ADDR_WIDTH'(wrap_addr(32'(r_addr0), 32'd3, 32'(MEM_SIZE)));
        r_remaining <= r_remaining - ADDR_WIDTH'(1);
      end
    end
  end

  pair_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_pair_fifo (
    .clk     (Clock),
    .rst     (Reset),
    .i_push  (w_push),
    .i_data  ({iRamData0, iRamData1}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

endmodule
`default_nettype wire
